// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: boot hold, D-miss freeze, branch flush, load-use interlock.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int NREGS       = 4,
   parameter int REG_BITS    = 5,
   parameter int BOOT_CYCLES = 3,
   parameter int CNT_BITS    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [REG_BITS-1:0] id_rs1,
   input  logic [REG_BITS-1:0] id_rs2,
   input  logic                id_use_rs1,
   input  logic                id_use_rs2,
   input  logic [REG_BITS-1:0] ex_rd,
   input  logic                ex_is_load,
   input  logic                ex_branch_taken,
   input  logic                mem_miss,
   input  logic                mem_ready,
   output logic                pc_en,
   output logic [NREGS-1:0]    stage_en,
   output logic [NREGS-1:0]    stage_flush,
   output logic [1:0]          ctrl_state,
   output logic [CNT_BITS-1:0] stall_cycles,
   output logic [CNT_BITS-1:0] flush_count
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_MISS = 2'd2
   } state_e;

   localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

   state_e     state_q, state_d;
   logic [3:0] boot_cnt_q, boot_cnt_d;
   logic       load_use;
   logic       miss_start;

   // x0 is hardwired zero, so a load targeting it never blocks a consumer.
   assign load_use = ex_is_load && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   // A miss coinciding with its own fill pulse behaves as a hit.
   assign miss_start = mem_miss && !mem_ready;

   always_comb begin
      // NOTE: every output gets a default before the case so no path infers a latch.
      state_d     = state_q;
      boot_cnt_d  = boot_cnt_q;
      pc_en       = 1'b0;
      stage_en    = '0;
      stage_flush = '0;
      case (state_q)
         ST_BOOT: begin
            stage_en    = '1;
            stage_flush = '1;
            if (boot_cnt_q == 4'd0) state_d = ST_RUN;
            else                    boot_cnt_d = boot_cnt_q - 4'd1;
         end
         ST_RUN: begin
            if (miss_start) begin
               state_d = ST_MISS;
            end else if (ex_branch_taken) begin
               pc_en            = 1'b1;
               stage_en         = '1;
               stage_flush[1:0] = 2'b11;
            end else if (load_use) begin
               stage_en       = '1;
               stage_en[0]    = 1'b0;
               stage_flush[1] = 1'b1;
            end else begin
               pc_en    = 1'b1;
               stage_en = '1;
            end
         end
         ST_MISS: begin
            if (mem_ready) begin
               pc_en    = 1'b1;
               stage_en = '1;
               state_d  = ST_RUN;
            end
         end
         default: begin
            stage_en    = '1;
            stage_flush = '1;
            state_d     = ST_BOOT;
            boot_cnt_d  = BOOT_INIT;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_BOOT;
         boot_cnt_q <= BOOT_INIT;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
      end
   end

   assign ctrl_state = state_q;

`ifdef PIPE_PERF_CNT_EN
   localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

   logic [CNT_BITS-1:0] stall_q, stall_d, flush_q, flush_d;
   logic                branch_win;

   assign branch_win = (state_q == ST_RUN) && !miss_start && ex_branch_taken;

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if ((state_q == ST_RUN || state_q == ST_MISS) && !pc_en && (stall_q != '1))
         stall_d = stall_q + CNT_ONE;
      if (branch_win && (flush_q != '1))
         flush_d = flush_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic       rst_n;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       ld;
      logic       br;
      logic       miss;
      logic       rdy;
   } stim_t;

   typedef struct {
      logic        pc;
      logic [3:0]  en;
      logic [3:0]  fl;
      logic [1:0]  st;
      logic [15:0] stall;
      logic [15:0] fcnt;
   } exp_t;

   logic        clk, reset;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken, mem_miss, mem_ready;
   logic        pc_en;
   logic [3:0]  stage_en, stage_flush;
   logic [1:0]  ctrl_state;
   logic [15:0] stall_cycles, flush_count;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] m_stall  = '0;
   logic [15:0] m_flush  = '0;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
      .mem_miss(mem_miss), .mem_ready(mem_ready),
      .pc_en(pc_en), .stage_en(stage_en), .stage_flush(stage_flush), .ctrl_state(ctrl_state),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s       = '0;
      s.rst_n = 1'b1;
      return s;
   endfunction

   // Apply one cycle of stimulus just after the edge and queue the expected response.
   task automatic step(input stim_t s, input logic pc, input logic [3:0] en,
                       input logic [3:0] fl, input logic [1:0] st,
                       input bit br_win, input bit chk);
      exp_t e;
      @(posedge clk);
      #1;
      reset = s.rst_n;   id_rs1 = s.rs1;  id_rs2 = s.rs2;
      id_use_rs1 = s.u1; id_use_rs2 = s.u2; ex_rd = s.rd;
      ex_is_load = s.ld; ex_branch_taken = s.br;
      mem_miss = s.miss; mem_ready = s.rdy;
      if (!s.rst_n) begin
         m_stall = '0;
         m_flush = '0;
      end
      if (chk) begin
         e.pc = pc; e.en = en; e.fl = fl; e.st = st;
         e.stall = PERF ? m_stall : 16'h0;
         e.fcnt  = PERF ? m_flush : 16'h0;
         sb.push_back(e);
      end
      if (s.rst_n && (st == 2'd1 || st == 2'd2) && !pc && m_stall != 16'hFFFF) m_stall++;
      if (s.rst_n && br_win && m_flush != 16'hFFFF) m_flush++;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ctrl_state",   {30'd0, ctrl_state},   {30'd0, e.st});
            check("pc_en",        {31'd0, pc_en},        {31'd0, e.pc});
            check("stage_en",     {28'd0, stage_en},     {28'd0, e.en});
            check("stage_flush",  {28'd0, stage_flush},  {28'd0, e.fl});
            check("stall_cycles", {16'd0, stall_cycles}, {16'd0, e.stall});
            check("flush_count",  {16'd0, flush_count},  {16'd0, e.fcnt});
         end
      end
   end

   initial begin : driver
      stim_t s, rst, haz, miss;
      reset = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rd = '0; ex_is_load = 1'b0; ex_branch_taken = 1'b0; mem_miss = 1'b0; mem_ready = 1'b0;

      rst = '0;
      haz = idle(); haz.ld = 1'b1; haz.rd = 5'd5; haz.rs2 = 5'd5; haz.u2 = 1'b1;
      miss = idle(); miss.miss = 1'b1;

      // Reset held, then release: three BOOT cycles then RUN.
      step(rst, 1'b0, 4'hF, 4'hF, 2'd0, 0, 1);
      step(rst, 1'b0, 4'hF, 4'hF, 2'd0, 0, 1);
      for (int i = 0; i < 3; i++) step(haz, 1'b0, 4'hF, 4'hF, 2'd0, 0, 1);
      step(idle(), 1'b1, 4'hF, 4'h0, 2'd1, 0, 1);

      // Load-use on rs2 stalls exactly one cycle.
      step(haz, 1'b0, 4'hE, 4'h2, 2'd1, 0, 1);
      step(idle(), 1'b1, 4'hF, 4'h0, 2'd1, 0, 1);
      s = haz; s.rd = 5'd0; s.rs2 = 5'd0;
      step(s, 1'b1, 4'hF, 4'h0, 2'd1, 0, 1);
      s = idle(); s.ld = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b1;
      step(s, 1'b0, 4'hE, 4'h2, 2'd1, 0, 1);
      s.u1 = 1'b0;
      step(s, 1'b1, 4'hF, 4'h0, 2'd1, 0, 1);
      s.u1 = 1'b1; s.ld = 1'b0;
      step(s, 1'b1, 4'hF, 4'h0, 2'd1, 0, 1);

      // Branch with a simultaneous hazard: branch wins, no stall.
      s = haz; s.br = 1'b1;
      step(s, 1'b1, 4'hF, 4'h3, 2'd1, 1, 1);
      step(idle(), 1'b1, 4'hF, 4'h0, 2'd1, 0, 1);

      // Miss together with ready in RUN is a hit.
      s = idle(); s.miss = 1'b1; s.rdy = 1'b1;
      step(s, 1'b1, 4'hF, 4'h0, 2'd1, 0, 1);
      s.br = 1'b1;
      step(s, 1'b1, 4'hF, 4'h3, 2'd1, 1, 1);

      // Miss held six cycles, ready pulses in the sixth; branch during MISS ignored.
      step(miss, 1'b0, 4'h0, 4'h0, 2'd1, 0, 1);
      s = miss; s.br = 1'b1; s.ld = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
      step(s, 1'b0, 4'h0, 4'h0, 2'd2, 0, 1);
      for (int i = 0; i < 3; i++) step(miss, 1'b0, 4'h0, 4'h0, 2'd2, 0, 1);
      s = miss; s.rdy = 1'b1;
      step(s, 1'b1, 4'hF, 4'h0, 2'd2, 0, 1);
      step(idle(), 1'b1, 4'hF, 4'h0, 2'd1, 0, 1);

      // Reset asserted mid-MISS returns to BOOT at once with counters cleared.
      step(miss, 1'b0, 4'h0, 4'h0, 2'd1, 0, 1);
      s = miss; s.br = 1'b1;
      step(s, 1'b0, 4'h0, 4'h0, 2'd2, 0, 1);
      s = miss; s.rst_n = 1'b0;
      step(s, 1'b0, 4'hF, 4'hF, 2'd0, 0, 1);
      for (int i = 0; i < 3; i++) step(miss, 1'b0, 4'hF, 4'hF, 2'd0, 0, 1);
      step(idle(), 1'b1, 4'hF, 4'h0, 2'd1, 0, 1);

      // Saturation: 2^16+3 stall cycles in a long miss.
      for (int i = 0; i < 65539; i++)
         step(miss, 1'b0, 4'h0, 4'h0, (i == 0) ? 2'd1 : 2'd2, 0, i >= 65533);
      step(miss, 1'b0, 4'h0, 4'h0, 2'd2, 0, 1);
      s = miss; s.rdy = 1'b1;
      step(s, 1'b1, 4'hF, 4'h0, 2'd2, 0, 1);
      step(idle(), 1'b1, 4'hF, 4'h0, 2'd1, 0, 1);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the in-order 5-stage core's pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Drives each register's enable and a synchronous-clear (bubble) request, plus the PC register enable.
- Resolves four conditions:
  - post-reset boot hold
  - data-memory miss stalls
  - taken-branch flushes
  - load-use interlocks
- Sits beside the datapath; a stage register loads when its enable is high, and loads zero (a bubble) when its flush is high.

Parameters:
- NREGS, 4, number of pipeline registers; bit i maps as 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB.
- REG_BITS, 5, register-index width.
- BOOT_CYCLES, 3, cycles all registers are held and flushed after reset deasserts; valid range 1..15.
- CNT_BITS, 16, width of performance counters.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- id_rs1  in  REG_BITS  source register 1 of the instruction in ID.
- id_rs2  in  REG_BITS  source register 2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_BITS  destination register of the instruction in EX.
- ex_is_load  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- mem_miss  in  1  MEM stage access missed; level signal, held until serviced.
- mem_ready  in  1  miss fill complete; single-cycle pulse.
- pc_en  out  1  PC register load enable.
- stage_en  out  NREGS  pipeline register load enables.
- stage_flush  out  NREGS  pipeline register bubble requests; a flushed register also has stage_en=1.
- ctrl_state  out  2  current state: 0=BOOT, 1=RUN, 2=MISS.
- stall_cycles  out  CNT_BITS  performance counter (feature-gated).
- flush_count  out  CNT_BITS  performance counter (feature-gated).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=BOOT, boot counter=BOOT_CYCLES-1, counters=0.
  - Outputs while reset is low: pc_en=0, stage_en=all 1, stage_flush=all 1, so every register clears on each edge.
- Outputs are combinational from the registered state plus the current inputs, with zero-cycle latency to the datapath enables.
- BOOT:
  - pc_en=0, stage_en=all 1, stage_flush=all 1.
  - The counter decrements each cycle; when it is 0, the next state is RUN.
  - Inputs are ignored.
- RUN, condition priority (highest first):
  1. mem_miss=1 and mem_ready=0:
     - pc_en=0, stage_en=0000, stage_flush=0000.
     - next=MISS.
  2. ex_branch_taken=1:
     - pc_en=1, stage_en=1111, stage_flush=0011 (IF/ID and ID/EX bubbled).
     - Any simultaneous load-use hazard is discarded because the ID instruction is squashed.
  3. Load-use hazard: ex_is_load=1, ex_rd!=0, and either (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd):
     - pc_en=0, stage_en=1110 (IF/ID held), stage_flush=0010 (bubble into EX).
     - Stay in RUN. The hazard clears on the next cycle because the load has advanced.
  4. Otherwise: pc_en=1, stage_en=1111, stage_flush=0000.
- MISS:
  - pc_en=0, stage_en=0000, stage_flush=0000; the entire pipeline is frozen, branch and hazard inputs are ignored.
  - When mem_ready=1, that same cycle: pc_en=1, stage_en=1111, flush=0000; next=RUN.
- A simultaneous mem_miss and mem_ready in RUN is treated as a hit: the miss condition is not taken and evaluation falls through to priority items 2-4.
- Register x0 (index 0) never creates a hazard.
- Reset asserted during MISS or BOOT returns to BOOT immediately, with the full BOOT_CYCLES hold after release.
- ctrl_state encoding 3 is unused; if reached, the next state is BOOT.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - stall_cycles increments every cycle that pc_en=0 while in RUN or MISS.
  - flush_count increments once per cycle that the taken-branch condition wins priority.
  - Both counters saturate at all-ones (no wrap) and clear on reset.
- Undefined: counter flops are removed and both outputs are tied to 0.

Test Plan:
- Reset release, BOOT_CYCLES=3:
  - Expect ctrl_state=0 for 3 rising edges with stage_flush=1111 and pc_en=0.
  - Expect ctrl_state=1 and pc_en=1 on the 4th cycle.
- Load-use, ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1:
  - Expect pc_en=0, stage_en=1110, stage_flush=0010 for exactly 1 cycle, then 1111/0000.
  - Repeat with ex_rd=0: expect no stall.
- Branch and hazard in the same cycle:
  - Expect pc_en=1, stage_flush=0011, no stall.
  - flush_count goes 0→1 with PIPE_PERF_CNT_EN defined.
- mem_miss held 6 cycles, mem_ready pulses in cycle 6:
  - Expect ctrl_state=2 and stage_en=0000 for 5 cycles, resume on the pulse cycle.
  - stall_cycles=5.
- Branch asserted during MISS: ignored, no flush. Then reset low mid-MISS: expect ctrl_state=0 immediately and counters=0.
- Saturation: force 2^CNT_BITS+3 stall cycles; stall_cycles holds at 0xFFFF.
